// File: rtl/imem_responder.sv
// imem_responder
//   Memory side of the instruction-fetch interface. This block accepts
//   byte-addressed fetch requests and returns 32-bit instruction words.
//   It uses valid/ready handshakes on both channels. A response becomes
//   eligible a fixed LATENCY after its request is accepted. It then waits
//   in a QDEPTH-entry response queue until the fetch side takes it.
//
//   Handshake rule, used on both channels: a transfer happens on a rising
//   clk edge when valid && ready are both high. The initiator holds the
//   payload stable while valid is high and ready is low.
//
// Ports
//   clk, reset_n                 clock (rising edge); async active-low reset
//   req_valid/req_ready/req_addr fetch request channel (64-bit byte address)
//   rsp_valid/rsp_ready          response channel handshake
//   rsp_inst/rsp_err/rsp_addr    response payload: word, error flag, echoed addr
//   flush                        synchronous drop of everything outstanding
//   wr_en/wr_idx/wr_data         preload write port into the word array
module imem_responder #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned QDEPTH  = 4,
  parameter logic [31:0] NOP     = 32'h00000013,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [63:0]   req_addr,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_inst,
  output logic          rsp_err,
  output logic [63:0]   rsp_addr,
  input  logic          flush,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_idx,
  input  logic [31:0]   wr_data
);

  localparam int unsigned QW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CW = $clog2(QDEPTH + 1);

  typedef struct packed {
    logic        err;
    logic [63:0] addr;
    logic [31:0] inst;
  } rsp_t;

  logic [31:0]   mem [DEPTH];
  logic          accept;
  logic          pop;
  logic          in_err;
  rsp_t          in_rsp;
  logic          push;
  rsp_t          push_rsp;
  rsp_t          q [QDEPTH];
  logic [QW-1:0] rd_ptr;
  logic [QW-1:0] wr_ptr;
  logic [CW-1:0] q_used;
  logic [CW-1:0] count;

  function automatic logic [QW-1:0] ptr_inc(input logic [QW-1:0] p);
    return (p == QW'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // The credit count covers requests in the pipeline and in the queue.
  // The queue therefore always has room for whatever leaves the pipeline.
  // The reset_n term keeps req_ready low while reset is asserted.
  assign req_ready = reset_n && !flush && (count < CW'(QDEPTH));
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (q_used != '0);
  // A pop that coincides with a flush is discarded along with the queue.
  assign pop       = rsp_valid && rsp_ready && !flush;

  // Preload port. The array is not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  // The read is taken combinationally at the accept edge. A write on that
  // same edge is therefore not yet visible to the read.
  assign in_err      = (|req_addr[1:0]) || (|req_addr[63:2+AW]);
  assign in_rsp.err  = in_err;
  assign in_rsp.addr = req_addr;
  assign in_rsp.inst = in_err ? NOP : mem[req_addr[2 +: AW]];

  // A fixed-latency shift feeds the queue. The queue push is the final
  // stage, so only LATENCY-1 register stages are needed here.
  generate
    if (LATENCY == 1) begin : g_lat1
      assign push     = accept;
      assign push_rsp = in_rsp;
    end else begin : g_pipe
      logic [LATENCY-2:0] p_valid;
      rsp_t               p_rsp [LATENCY-1];

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          p_valid <= '0;
          for (int k = 0; k < LATENCY - 1; k++) p_rsp[k] <= '0;
        end else begin
          // accept is already low during a flush
          p_valid[0] <= accept;
          p_rsp[0]   <= in_rsp;
          for (int k = 1; k < LATENCY - 1; k++) begin
            p_valid[k] <= p_valid[k-1] && !flush;
            p_rsp[k]   <= p_rsp[k-1];
          end
        end
      end

      assign push     = p_valid[LATENCY-2] && !flush;
      assign push_rsp = p_rsp[LATENCY-2];
    end
  endgenerate

  // Response queue. The head entry drives the rsp_* outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      q_used <= '0;
      for (int k = 0; k < QDEPTH; k++) q[k] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      q_used <= '0;
    end else begin
      if (push) begin
        q[wr_ptr] <= push_rsp;
        wr_ptr    <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      q_used <= q_used + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   count <= '0;
    else if (flush) count <= '0;
    else            count <= count + CW'(accept) - CW'(pop);
  end

  assign rsp_inst = q[rd_ptr].inst;
  assign rsp_err  = q[rd_ptr].err;
  assign rsp_addr = q[rd_ptr].addr;

  a_count_bound : assert property (@(posedge clk) disable iff (!reset_n)
    count <= CW'(QDEPTH));
  a_queue_in_credit : assert property (@(posedge clk) disable iff (!reset_n)
    q_used <= count);

endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder
//   Directed bench for imem_responder (DEPTH=256, LATENCY=2, QDEPTH=4).
//   Inputs change 1 time unit after a rising edge. Outputs are observed at
//   that same point, which is after the edge has settled.
module tb_imem_responder;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_inst;
  logic        rsp_err;
  logic [63:0] rsp_addr;
  logic        flush;
  logic        wr_en;
  logic [7:0]  wr_idx;
  logic [31:0] wr_data;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  imem_responder #(.DEPTH(256), .LATENCY(2), .QDEPTH(4), .NOP(NOP)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_inst  (rsp_inst),
    .rsp_err   (rsp_err),
    .rsp_addr  (rsp_addr),
    .flush     (flush),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .wr_data   (wr_data)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] data);
    wr_en = 1'b1; wr_idx = idx; wr_data = data;
    tick();
    wr_en = 1'b0;
  endtask

  // A single request with rsp_ready high. The response is visible after
  // the second edge. The response channel must be empty one edge later.
  task automatic single(input string tag, input logic [63:0] addr,
                        input logic [31:0] exp_inst, input logic exp_err);
    req_valid = 1'b1; req_addr = addr;
    tick();
    req_valid = 1'b0;
    check({tag, "_early"}, rsp_valid, 1'b0);
    tick();
    check({tag, "_valid"}, rsp_valid, 1'b1);
    check({tag, "_inst"},  rsp_inst,  exp_inst);
    check({tag, "_err"},   rsp_err,   exp_err);
    check({tag, "_addr"},  rsp_addr,  addr);
    tick();
    check({tag, "_drain"}, rsp_valid, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
    flush = 1'b0; wr_en = 1'b0; wr_idx = '0; wr_data = '0;
    repeat (2) tick();
    check("rst_ready", req_ready, 1'b0);
    check("rst_valid", rsp_valid, 1'b0);
    check("rst_inst",  rsp_inst,  32'h0);
    check("rst_err",   rsp_err,   1'b0);
    check("rst_addr",  rsp_addr,  64'h0);
    reset_n = 1'b1;
    tick();
    check("rst_release_ready", req_ready, 1'b1);

    preload(8'd0, 32'd11);
    preload(8'd1, 32'd22);
    preload(8'd2, 32'd33);
    preload(8'd3, 32'd44);
    preload(8'd255, 32'h55);

    // 1: reset with three requests outstanding
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_addr = 64'(i * 4);
      tick();
    end
    req_valid = 1'b0;
    check("t1_count3", dut.count, 3);
    check("t1_busy", rsp_valid, 1'b1);
    reset_n = 1'b0;
    #1;
    check("t1_async_valid", rsp_valid, 1'b0);
    check("t1_async_ready", req_ready, 1'b0);
    tick();
    check("t1_rst_valid", rsp_valid, 1'b0);
    check("t1_rst_ready", req_ready, 1'b0);
    check("t1_rst_inst",  rsp_inst, 32'h0);
    reset_n = 1'b1;
    tick();
    check("t1_rel_ready", req_ready, 1'b1);
    check("t1_rel_count", dut.count, 0);
    check("t1_rel_valid", rsp_valid, 1'b0);

    // 2: back-to-back requests return on consecutive cycles
    exp_q.push_back(32'd11); exp_q.push_back(32'd22);
    exp_q.push_back(32'd33); exp_q.push_back(32'd44);
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_addr = 64'(i * 4);
      check("t2_ready", req_ready, 1'b1);
      tick();
      if (i == 0) begin
        check("t2_latency", rsp_valid, 1'b0);
      end else begin
        check("t2_valid", rsp_valid, 1'b1);
        check("t2_inst", rsp_inst, exp_q.pop_front());
      end
    end
    req_valid = 1'b0;
    tick();
    check("t2_valid", rsp_valid, 1'b1);
    check("t2_inst", rsp_inst, exp_q.pop_front());
    tick();
    check("t2_empty", rsp_valid, 1'b0);

    // 3: backpressure fills the credits; the head holds; the queue drains in order
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_addr = 64'(i * 4);
      tick();
    end
    check("t3_full_ready", req_ready, 1'b0);
    check("t3_full_count", dut.count, 4);
    req_addr = 64'h4;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("t3_hold_inst",  rsp_inst, 32'd11);
      check("t3_hold_addr",  rsp_addr, 64'h0);
      check("t3_hold_valid", rsp_valid, 1'b1);
      check("t3_blocked",    req_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    #1;
    check("t3_pop_no_ready", req_ready, 1'b0);
    exp_q.push_back(32'd22); exp_q.push_back(32'd33);
    exp_q.push_back(32'd44); exp_q.push_back(32'd22);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 1) req_valid = 1'b0;
      check("t3_valid", rsp_valid, 1'b1);
      check("t3_inst", rsp_inst, exp_q.pop_front());
    end
    check("t3_fifth_addr", rsp_addr, 64'h4);
    tick();
    check("t3_empty", rsp_valid, 1'b0);

    // 4: error responses and the address boundary
    single("t4_misalign", 64'h2,   NOP,    1'b1);
    single("t4_range",    64'h400, NOP,    1'b1);
    single("t4_last",     64'h3FC, 32'h55, 1'b0);
    single("t4_high",     64'h8000_0000_0000_0000, NOP, 1'b1);

    // 5: flush with two queued and one in flight; a pop during the flush is lost
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_addr = 64'(i * 4);
      tick();
    end
    flush = 1'b1; req_addr = 64'hC; rsp_ready = 1'b1;
    #1;
    check("t5_flush_ready", req_ready, 1'b0);
    tick();
    flush = 1'b0; req_valid = 1'b0;
    check("t5_flushed_valid", rsp_valid, 1'b0);
    check("t5_flushed_count", dut.count, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t5_quiet", rsp_valid, 1'b0);
    end
    single("t5_after", 64'h4, 32'd22, 1'b0);

    // 6: a write on the accept edge is seen only by the next request
    wr_en = 1'b1; wr_idx = 8'd1; wr_data = 32'd99;
    req_valid = 1'b1; req_addr = 64'h4; rsp_ready = 1'b1;
    tick();
    wr_en = 1'b0;
    tick();
    req_valid = 1'b0;
    check("t6_old_valid", rsp_valid, 1'b1);
    check("t6_old_inst", rsp_inst, 32'd22);
    tick();
    check("t6_new_valid", rsp_valid, 1'b1);
    check("t6_new_inst", rsp_inst, 32'd99);
    tick();
    check("t6_empty", rsp_valid, 1'b0);

    check("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // safety bound on total run time
  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
